// File: rtl/user_input_irq_ctrl.sv
// Avalon-MM key/switch input block: 2-FF sync, debounce, edge capture and one level irq.
// Build option: define USER_INPUT_DEBOUNCE_EN for counter-based debounce; otherwise stable = synced input.
module user_input_irq_ctrl #(
  parameter int          N_KEYS          = 4,
  parameter int          N_SW            = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] RST_STATE       = 32'hF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  input  logic [N_KEYS-1:0]   keys_in,
  input  logic [N_SW-1:0]     switches_in,
  output logic                irq
);

  localparam int N = N_KEYS + N_SW;
  localparam logic [N-1:0] RST_V = RST_STATE[N-1:0];

  if (N > 32) begin : g_bad_width
    $error("N_KEYS + N_SW must not exceed 32");
  end
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic [N-1:0] raw, sync_p0, sync_p1, stable, stable_d;
  logic [N-1:0] rise, fall, hit;
  logic [N-1:0] mask_q, edge_q, edgesel_q;
  logic [N-1:0] wdata, clr;
  logic         wr_mask, wr_edge, wr_edgesel;
  logic [31:0]  rd_mux;

  assign raw = {switches_in, keys_in};

  // Stage p0/p1: two-flop synchroniser for asynchronous pins
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_p0 <= RST_V;
      sync_p1 <= RST_V;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef USER_INPUT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] cnt [N];

  // Debounce: a level is accepted only after it disagrees with stable for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable <= RST_V;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign stable = sync_p1;
`endif

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;
  assign hit  = (edgesel_q & rise) | (~edgesel_q & fall);

  assign wdata      = avs_writedata[N-1:0];
  assign wr_mask    = avs_write && (avs_address == 2'd1);
  assign wr_edge    = avs_write && (avs_address == 2'd2);
  assign wr_edgesel = avs_write && (avs_address == 2'd3);
  assign clr        = wr_edge ? wdata : '0;

  if (N < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:N];
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[N-1:0] = stable;
      2'd1:    rd_mux[N-1:0] = mask_q;
      2'd2:    rd_mux[N-1:0] = edge_q;
      default: rd_mux[N-1:0] = edgesel_q;
    endcase
  end

  // Stage p2: edge history, register file, capture, irq and read port
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable_d     <= RST_V;
      mask_q       <= '0;
      edge_q       <= '0;
      edgesel_q    <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      stable_d <= stable;
      if (wr_mask)    mask_q    <= wdata;
      if (wr_edgesel) edgesel_q <= wdata;
      // A new hit overrides a simultaneous write-1-to-clear
      edge_q <= hit | (edge_q & ~clr);
      irq    <= |(edge_q & mask_q);
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_user_input_irq_ctrl.sv
// Directed bench for user_input_irq_ctrl (DEBOUNCE_CYCLES=8); adapts latency to USER_INPUT_DEBOUNCE_EN.
module tb_user_input_irq_ctrl;

`ifdef USER_INPUT_DEBOUNCE_EN
  localparam int LAT = 2 + 8;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic [3:0]  keys_in, switches_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  user_input_irq_ctrl #(
    .N_KEYS(4), .N_SW(4), .DEBOUNCE_CYCLES(8), .CNT_W(4), .RST_STATE(32'hF)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .keys_in(keys_in), .switches_in(switches_in), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    keys_in = 4'hF; switches_in = 4'h0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    rd_chk("reset_data", 2'd0, 32'h0000000F);
    rd_chk("reset_mask", 2'd1, 32'h0);
    rd_chk("reset_edge", 2'd2, 32'h0);
    rd_chk("reset_edgesel", 2'd3, 32'h0);

    // 2: key 0 press, exact latency to DATA, irq one cycle after capture
    wr(2'd1, 32'h1);
    avs_address = 2'd0; avs_read = 1'b1;
    keys_in[0] = 1'b0;
    repeat (LAT) tick();
    check("press_data_before", avs_readdata, 32'h0000000F);
    tick();
    check("press_data_after", avs_readdata, 32'h0000000E);
    check("press_irq_capture_cycle", 32'(irq), 32'h0);
    tick();
    check("press_irq", 32'(irq), 32'h1);
    avs_read = 1'b0;
    rd_chk("press_edge", 2'd2, 32'h1);

`ifdef USER_INPUT_DEBOUNCE_EN
    // 3: glitch shorter than the debounce window is rejected
    keys_in[1] = 1'b0;
    repeat (5) tick();
    keys_in[1] = 1'b1;
    repeat (20) tick();
    rd_chk("glitch_data", 2'd0, 32'h0000000E);
    rd_chk("glitch_edge", 2'd2, 32'h1);
    check("glitch_irq", 32'(irq), 32'h1);
`else
    // 6: one-cycle pulse passes straight through
    avs_address = 2'd0; avs_read = 1'b1;
    keys_in[2] = 1'b0;
    tick();
    keys_in[2] = 1'b1;
    tick();
    check("pulse_data_e2", avs_readdata, 32'h0000000E);
    tick();
    check("pulse_data_e3", avs_readdata, 32'h0000000A);
    tick();
    check("pulse_data_e4", avs_readdata, 32'h0000000E);
    avs_read = 1'b0;
    rd_chk("pulse_edge", 2'd2, 32'h5);
    wr(2'd2, 32'h4);
    rd_chk("pulse_edge_clr", 2'd2, 32'h1);
`endif

    // 4: W1C colliding with a new hit, then plain W1C
    keys_in[0] = 1'b1;
    repeat (LAT + 4) tick();
    rd_chk("release_no_capture", 2'd2, 32'h1);
    keys_in[0] = 1'b0;
    repeat (LAT) tick();
    wr(2'd2, 32'h1);
    rd_chk("w1c_collide_edge", 2'd2, 32'h1);
    check("w1c_collide_irq", 32'(irq), 32'h1);
    wr(2'd2, 32'h1);
    check("w1c_irq_same_cycle", 32'(irq), 32'h1);
    tick();
    check("w1c_irq_next", 32'(irq), 32'h0);
    rd_chk("w1c_edge", 2'd2, 32'h0);

    // 5: rising-edge capture on switch 0, mask behaviour, register access corners
    wr(2'd3, 32'h10);
    wr(2'd1, 32'h10);
    switches_in[0] = 1'b1;
    repeat (LAT + 3) tick();
    check("sw_rise_irq", 32'(irq), 32'h1);
    rd_chk("sw_rise_edge", 2'd2, 32'h10);
    rd_chk("sw_rise_data", 2'd0, 32'h1E);
    wr(2'd1, 32'h0);
    tick();
    check("masked_irq", 32'(irq), 32'h0);
    wr(2'd1, 32'h10);
    check("unmask_irq_same_cycle", 32'(irq), 32'h0);
    tick();
    check("unmask_irq_next", 32'(irq), 32'h1);
    avs_address = 2'd1; avs_writedata = 32'h11; avs_read = 1'b1; avs_write = 1'b1;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_addr_prewrite", avs_readdata, 32'h10);
    rd_chk("rw_same_addr_written", 2'd1, 32'h11);
    check("readdata_hold", avs_readdata, 32'h11);
    wr(2'd1, 32'hFFFFFFFF);
    rd_chk("mask_upper_ignored", 2'd1, 32'hFF);
    wr(2'd1, 32'h10);
    wr(2'd2, 32'h10);
    tick();
    check("sw_clr_irq", 32'(irq), 32'h0);
    switches_in[0] = 1'b0;
    repeat (LAT + 4) tick();
    rd_chk("sw_fall_no_capture", 2'd2, 32'h0);
    check("sw_fall_irq", 32'(irq), 32'h0);
    rd_chk("sw_fall_data", 2'd0, 32'h0E);

    // Mid-operation asynchronous reset, then transitions from pins held opposite to reset state
    keys_in[3] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    check("async_reset_readdata", avs_readdata, 32'h0);
    tick();
    rst = 1'b0;
    rd_chk("post_reset_data", 2'd0, 32'h0F);
    rd_chk("post_reset_edgesel", 2'd3, 32'h0);
    repeat (LAT + 3) tick();
    rd_chk("post_reset_edge", 2'd2, 32'h9);
    rd_chk("post_reset_data_settled", 2'd0, 32'h06);
    check("post_reset_irq_masked", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
